// File: rtl/seq_det_1010.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_1010
// Brief    : Moore FSM detecting the serial pattern 1010 (overlap allowed),
//            with an optional saturating detection counter enabled by the
//            macro SEQ_DET_1010_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_1010 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  output logic             z,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] det_cnt
);

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  logic [2:0] state_q;
  logic [2:0] state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = x ? S1 : S0;
      S1:      state_d = x ? S1 : S2;
      S2:      state_d = x ? S3 : S0;
      S3:      state_d = x ? S1 : S4;
      S4:      state_d = x ? S3 : S0;  // trailing "10" of a match starts the next one
      default: state_d = S0;
    endcase
  end

  always_comb begin
    z     = (state_q == S4);
    state = state_q;
  end

`ifdef SEQ_DET_1010_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // S4 is only ever entered from S3, so state_d==S4 marks exactly one edge per match
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == S4) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign det_cnt = cnt_q;
`else
  assign det_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_1010.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_1010
// Brief    : Table-driven scoreboard bench for seq_det_1010 (CNT_W=8 and CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_1010;

  typedef struct {
    logic       rst;
    logic       x;
    logic [2:0] st;
    logic       z;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       z;
    int         cnt8;
    int         cnt2;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       x;
  logic       z;
  logic [2:0] state;
  logic [7:0] det_cnt;
  logic       z2;
  logic [2:0] state2;
  logic [1:0] det_cnt2;

  int n_cmp;
  int n_err;
  int model_cnt;

  vec_t vecs[$];
  exp_t sb[$];

  seq_det_1010 #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .x(x), .z(z), .state(state), .det_cnt(det_cnt)
  );

  seq_det_1010 #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .x(x), .z(z2), .state(state2), .det_cnt(det_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void add(input logic r, input logic xi, input int st, input logic zz);
    vec_t v;
    v.rst = r;
    v.x   = xi;
    v.st  = 3'(st);
    v.z   = zz;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst;
    x   = v.x;
    if (v.rst) model_cnt = 0;
    else if (v.z) model_cnt++;
    e.st = v.st;
    e.z  = v.z;
`ifdef SEQ_DET_1010_CNT_EN
    e.cnt8 = (model_cnt > 255) ? 255 : model_cnt;
    e.cnt2 = (model_cnt > 3) ? 3 : model_cnt;
`else
    e.cnt8 = 0;
    e.cnt2 = 0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("state",    int'(state),    int'(e.st));
    chk("z",        int'(z),        int'(e.z));
    chk("det_cnt",  int'(det_cnt),  e.cnt8);
    chk("state_w2", int'(state2),   int'(e.st));
    chk("z_w2",     int'(z2),       int'(e.z));
    chk("det_cnt_w2", int'(det_cnt2), e.cnt2);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_cnt = 0;
    rst = 1'b1;
    x   = 1'b0;

    // reset with x toggling
    add(1, 0, 0, 0); add(1, 1, 0, 0);
    // overlap stream: matches after bits 5, 7, 13, 15
    add(0, 1, 1, 0); add(0, 1, 1, 0); add(0, 0, 2, 0); add(0, 1, 3, 0);
    add(0, 0, 4, 1); add(0, 1, 3, 0); add(0, 0, 4, 1); add(0, 1, 3, 0);
    add(0, 1, 1, 0); add(0, 1, 1, 0); add(0, 0, 2, 0); add(0, 1, 3, 0);
    add(0, 0, 4, 1); add(0, 1, 3, 0); add(0, 0, 4, 1);
    // near misses
    add(1, 0, 0, 0);
    add(0, 1, 1, 0); add(0, 0, 2, 0); add(0, 0, 0, 0); add(0, 1, 1, 0);
    add(0, 0, 2, 0); add(0, 1, 3, 0); add(0, 1, 1, 0); add(0, 0, 2, 0);
    // reset in S3 with rst priority over x=0
    add(1, 0, 0, 0);
    add(0, 1, 1, 0); add(0, 0, 2, 0); add(0, 1, 3, 0);
    add(1, 0, 0, 0); add(0, 0, 0, 0);
    // reset while in S4 discards history
    add(0, 1, 1, 0); add(0, 0, 2, 0); add(0, 1, 3, 0); add(0, 0, 4, 1);
    add(1, 1, 0, 0); add(0, 1, 1, 0); add(0, 0, 2, 0);
    // saturation: five matches after reset
    add(1, 0, 0, 0);
    add(0, 1, 1, 0); add(0, 0, 2, 0); add(0, 1, 3, 0); add(0, 0, 4, 1);
    add(0, 1, 3, 0); add(0, 0, 4, 1); add(0, 1, 3, 0); add(0, 0, 4, 1);
    add(0, 1, 3, 0); add(0, 0, 4, 1); add(0, 1, 3, 0); add(0, 0, 4, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Moore check: now in S4; wiggle x mid-cycle, z must hold until the edge
    #1 x = 1'b1;
    #1 chk("moore_z_x1", int'(z), 1);
    x = 1'b0;
    #1 chk("moore_z_x0", int'(z), 1);
    x = 1'b1;
    #1 chk("moore_state", int'(state), 4);
    @(posedge clk);
    #1;
    chk("moore_after_edge_z", int'(z), 0);
    chk("moore_after_edge_state", int'(state), 3);

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_det_1010.md
SEQ_DET_1010 -- requirements
Module: seq_det_1010

Interface
REQ-001 Parameter CNT_W, default 8: width of the detection counter, legal range 1..16.
REQ-002 Port clk, input, 1 bit: sole clock; all state updates occur on the rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port x, input, 1 bit: serial data bit, sampled on every rising clk edge.
REQ-005 Port z, output, 1 bit: Moore detect flag, high while the FSM is in state S4.
REQ-006 Port state, output, 3 bits: current FSM state encoding, for debug.
REQ-007 Port det_cnt, output, CNT_W bits: saturating count of detections since reset.
REQ-008 Port order SHALL be clk, rst, x, z, state, det_cnt, so that positional instantiation with the first four ports is valid.

Function
REQ-009 The block SHALL detect the serial pattern 1010, first bit oldest, with overlapping matches allowed.
REQ-010 The FSM SHALL have exactly five states, encoded S0=0 (idle), S1=1 ("1"), S2=2 ("10"), S3=3 ("101") and S4=4 ("1010" found).
REQ-011 Transitions from S0 SHALL be x=1 -> S1, x=0 -> S0.
REQ-012 Transitions from S1 SHALL be x=1 -> S1, x=0 -> S2.
REQ-013 Transitions from S2 SHALL be x=1 -> S3, x=0 -> S0.
REQ-014 Transitions from S3 SHALL be x=1 -> S1, x=0 -> S4.
REQ-015 Transitions from S4 SHALL be x=1 -> S3 (overlap: the trailing "10" is reused), x=0 -> S0.
REQ-016 Encodings 5..7 SHALL be unreachable; if ever entered, the next clock edge SHALL move the FSM to S0 and z SHALL be 0.
REQ-017 z SHALL be decoded only from the state register (Moore), with no combinational path from x to z.
REQ-018 z SHALL go high in the cycle after the edge that samples the final 0 of a match, and SHALL stay high for exactly one cycle per match.
REQ-019 The state output SHALL equal the state register.
REQ-020 Back-to-back overlapping matches (x stream 1,0,1,0,1,0) SHALL produce z pulses two cycles apart.

Reset
REQ-021 When rst=1 at a rising clk edge, the FSM SHALL go to S0, z SHALL be 0 and det_cnt SHALL be 0 from the next cycle; rst takes priority over x.
REQ-022 Reset asserted mid-pattern, including while in S4, SHALL discard all partial history, so a match requires four fresh bits after release.
REQ-023 Before the first reset, output values are unspecified; the bench SHALL apply reset before checking outputs.

Configuration
REQ-024 With macro SEQ_DET_1010_CNT_EN defined, det_cnt SHALL increment by 1 on every edge that enters S4.
REQ-025 With SEQ_DET_1010_CNT_EN defined, det_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 Without SEQ_DET_1010_CNT_EN, det_cnt SHALL be constant 0, no counter flops SHALL be implemented, and z/state behaviour SHALL be unchanged.

Verification
REQ-027 Scenario, reset: rst=1 for 2 cycles with x toggling -> state=0, z=0, det_cnt=0.
REQ-028 Scenario, overlap stream: after reset, x=1,1,0,1,0,1,0,1,1,1,0,1,0,1,0 (one bit per cycle) -> z pulses after bits 5, 7, 13 and 15; det_cnt=4 (CNT_EN defined), 0 (undefined).
REQ-029 Scenario, near misses: x=1,0,0,1,0,1,1,0 -> z never high; state returns to S0 after the "100".
REQ-030 Scenario, mid-pattern reset: x=1,0,1, then rst=1 for one edge, then x=0 -> no z pulse; state=S0.
REQ-031 Scenario, saturation: with CNT_W=2 and CNT_EN defined, feed 5 matches -> det_cnt holds 3.
REQ-032 Scenario, Moore check: change x between edges while in S4 -> z does not change until the next rising edge.
